xillybus_mem_8_regfile: RTL and testbench

- Seekable 32 x 8 register file on the core's mem_8 user ports: user_r_mem_8_*, user_w_mem_8_*, user_mem_8_addr and user_mem_8_addr_update.
- Sits directly downstream of the PCIe/Xillybus wrapper in the top level, clocked by bus_clk.
- Provides a second, fabric-side port so application logic can read and write the same registers.
- Raises a per-write notification whenever the host writes a register.

---
 rtl/xillybus_mem_8_regfile_pkg.sv | 15 +
 rtl/xillybus_mem_8_regfile_dp_ram.sv | 82 ++++++++
 rtl/xillybus_mem_8_regfile.sv | 101 ++++++++++
 tb/tb_xillybus_mem_8_regfile.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/xillybus_mem_8_regfile_pkg.sv
`default_nettype none
// ============================================================================
// xillybus_mem_8_regfile_pkg: shared sizes and reset value for the mem_8 file
// Rev 1.0
// ============================================================================
package xillybus_mem_8_regfile_pkg;

  localparam int         MEM8_ADDR_W   = 5;
  localparam int         MEM8_DEPTH    = 1 << MEM8_ADDR_W;
  localparam logic [7:0] MEM8_INIT_VAL = 8'h00;

  typedef logic [7:0] mem8_byte_t;

endpackage : xillybus_mem_8_regfile_pkg
`default_nettype wire

// File: rtl/xillybus_mem_8_regfile_dp_ram.sv
`default_nettype none
// ============================================================================
// mem8_dp_ram: 2-write/2-read register array, port A wins write collisions
// Rev 1.0
// ============================================================================
module mem8_dp_ram
  import xillybus_mem_8_regfile_pkg::*;
#(
  parameter int         ADDR_W   = MEM8_ADDR_W,
  parameter mem8_byte_t INIT_VAL = MEM8_INIT_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_rden,
  input  logic              a_wren,
  input  logic [7:0]        a_wdata,
  output logic [7:0]        a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_wren,
  input  logic [7:0]        b_wdata,
  output logic [7:0]        b_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem_rd [DEPTH];
  logic       b_wr_ok;
  logic [7:0] a_rdata_q, a_rdata_d;
  logic [7:0] b_rdata_q, b_rdata_d;

  // A fabric write to the cell the host is writing this cycle is dropped.
  assign b_wr_ok = b_wren && !(a_wren && (a_addr == b_addr));

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic [7:0] cell_q, cell_d;

      always_comb begin
        cell_d = cell_q;
        if (a_wren && (a_addr == ADDR_W'(i))) begin
          cell_d = a_wdata;
        end else if (b_wr_ok && (b_addr == ADDR_W'(i))) begin
          cell_d = b_wdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cell_q <= INIT_VAL;
        end else begin
          cell_q <= cell_d;
        end
      end

      assign mem_rd[i] = cell_q;
    end
  endgenerate

  always_comb begin
    a_rdata_d = a_rdata_q;
    if (a_rden) begin
      a_rdata_d = mem_rd[a_addr];
    end
    b_rdata_d = mem_rd[b_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule : mem8_dp_ram
`default_nettype wire

// File: rtl/xillybus_mem_8_regfile.sv
`default_nettype none
// ============================================================================
// xillybus_mem_8_regfile: seekable 32x8 register file on the Xillybus mem_8 ports
// Rev 1.0
// ============================================================================
module xillybus_mem_8_regfile
  import xillybus_mem_8_regfile_pkg::*;
#(
  parameter int         ADDR_W   = MEM8_ADDR_W,
  parameter mem8_byte_t INIT_VAL = MEM8_INIT_VAL
) (
  input  logic              bus_clk,
  input  logic              trn_reset_n,
  input  logic              user_r_mem_8_rden,
  output logic [7:0]        user_r_mem_8_data,
  output logic              user_r_mem_8_empty,
  output logic              user_r_mem_8_eof,
  input  logic              user_r_mem_8_open,
  input  logic              user_w_mem_8_wren,
  input  logic [7:0]        user_w_mem_8_data,
  output logic              user_w_mem_8_full,
  input  logic              user_w_mem_8_open,
  input  logic [ADDR_W-1:0] user_mem_8_addr,
  input  logic              user_mem_8_addr_update,
  input  logic [ADDR_W-1:0] fab_addr,
  input  logic              fab_wren,
  input  logic [7:0]        fab_wdata,
  output logic [7:0]        fab_rdata,
  output logic              host_wr_stb,
  output logic [ADDR_W-1:0] host_wr_addr,
  output logic [7:0]        host_wr_data
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              host_wr_stb_q, host_wr_stb_d;
  logic [ADDR_W-1:0] host_wr_addr_q, host_wr_addr_d;
  logic [7:0]        host_wr_data_q, host_wr_data_d;
  logic              unused_open;

  // File open state never gates access and never rewinds the pointer.
  assign unused_open = user_r_mem_8_open ^ user_w_mem_8_open;

  always_comb begin
    ptr_d = ptr_q;
    if (user_mem_8_addr_update) begin
      ptr_d = user_mem_8_addr;
    end else if (user_r_mem_8_rden || user_w_mem_8_wren) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end

    host_wr_stb_d  = user_w_mem_8_wren;
    host_wr_addr_d = host_wr_addr_q;
    host_wr_data_d = host_wr_data_q;
    if (user_w_mem_8_wren) begin
      host_wr_addr_d = ptr_q;
      host_wr_data_d = user_w_mem_8_data;
    end
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      ptr_q          <= '0;
      host_wr_stb_q  <= 1'b0;
      host_wr_addr_q <= '0;
      host_wr_data_q <= 8'h00;
    end else begin
      ptr_q          <= ptr_d;
      host_wr_stb_q  <= host_wr_stb_d;
      host_wr_addr_q <= host_wr_addr_d;
      host_wr_data_q <= host_wr_data_d;
    end
  end

  // Host accesses always use the pre-seek pointer, even alongside addr_update.
  mem8_dp_ram #(
    .ADDR_W   (ADDR_W),
    .INIT_VAL (INIT_VAL)
  ) u_ram (
    .clk     (bus_clk),
    .rst_n   (trn_reset_n),
    .a_addr  (ptr_q),
    .a_rden  (user_r_mem_8_rden),
    .a_wren  (user_w_mem_8_wren),
    .a_wdata (user_w_mem_8_data),
    .a_rdata (user_r_mem_8_data),
    .b_addr  (fab_addr),
    .b_wren  (fab_wren),
    .b_wdata (fab_wdata),
    .b_rdata (fab_rdata)
  );

  assign user_r_mem_8_empty = 1'b0;
  assign user_r_mem_8_eof   = 1'b0;
  assign user_w_mem_8_full  = 1'b0;

  assign host_wr_stb  = host_wr_stb_q;
  assign host_wr_addr = host_wr_addr_q;
  assign host_wr_data = host_wr_data_q;

endmodule : xillybus_mem_8_regfile
`default_nettype wire

// File: tb/tb_xillybus_mem_8_regfile.sv
`default_nettype none
// ============================================================================
// tb_xillybus_mem_8_regfile: directed + random bench against a behavioural model
// Rev 1.0
// ============================================================================
module tb_xillybus_mem_8_regfile;

  logic       bus_clk = 1'b0;
  logic       trn_reset_n = 1'b0;
  logic       user_r_mem_8_rden = 1'b0;
  logic [7:0] user_r_mem_8_data;
  logic       user_r_mem_8_empty;
  logic       user_r_mem_8_eof;
  logic       user_r_mem_8_open = 1'b0;
  logic       user_w_mem_8_wren = 1'b0;
  logic [7:0] user_w_mem_8_data = 8'h00;
  logic       user_w_mem_8_full;
  logic       user_w_mem_8_open = 1'b0;
  logic [4:0] user_mem_8_addr = 5'd0;
  logic       user_mem_8_addr_update = 1'b0;
  logic [4:0] fab_addr = 5'd0;
  logic       fab_wren = 1'b0;
  logic [7:0] fab_wdata = 8'h00;
  logic [7:0] fab_rdata;
  logic       host_wr_stb;
  logic [4:0] host_wr_addr;
  logic [7:0] host_wr_data;

  always #5 bus_clk = ~bus_clk;

  xillybus_mem_8_regfile dut (
    .bus_clk                (bus_clk),
    .trn_reset_n            (trn_reset_n),
    .user_r_mem_8_rden      (user_r_mem_8_rden),
    .user_r_mem_8_data      (user_r_mem_8_data),
    .user_r_mem_8_empty     (user_r_mem_8_empty),
    .user_r_mem_8_eof       (user_r_mem_8_eof),
    .user_r_mem_8_open      (user_r_mem_8_open),
    .user_w_mem_8_wren      (user_w_mem_8_wren),
    .user_w_mem_8_data      (user_w_mem_8_data),
    .user_w_mem_8_full      (user_w_mem_8_full),
    .user_w_mem_8_open      (user_w_mem_8_open),
    .user_mem_8_addr        (user_mem_8_addr),
    .user_mem_8_addr_update (user_mem_8_addr_update),
    .fab_addr               (fab_addr),
    .fab_wren               (fab_wren),
    .fab_wdata              (fab_wdata),
    .fab_rdata              (fab_rdata),
    .host_wr_stb            (host_wr_stb),
    .host_wr_addr           (host_wr_addr),
    .host_wr_data           (host_wr_data)
  );

  // Behavioural model: register contents, seek pointer and expected outputs.
  logic [7:0] mdl_mem [32];
  int         mdl_ptr;
  logic [7:0] exp_rdata;
  logic [7:0] exp_fab;
  logic       exp_stb;
  logic [4:0] exp_waddr;
  logic [7:0] exp_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl_mem[i] = 8'h00;
    mdl_ptr   = 0;
    exp_rdata = 8'h00;
    exp_fab   = 8'h00;
    exp_stb   = 1'b0;
    exp_waddr = 5'd0;
    exp_wdata = 8'h00;
  endtask

  always @(negedge bus_clk) begin
    check("host_rdata", user_r_mem_8_data, exp_rdata);
    check("fab_rdata", fab_rdata, exp_fab);
    check("host_wr_stb", host_wr_stb, exp_stb);
    if (exp_stb) begin
      check("host_wr_addr", host_wr_addr, exp_waddr);
      check("host_wr_data", host_wr_data, exp_wdata);
    end
    check("empty_eof_full", {user_r_mem_8_empty, user_r_mem_8_eof, user_w_mem_8_full}, 3'b000);
  end

  // One clock of stimulus; the model predicts the state after the next edge.
  task automatic drive(input bit rd, input bit wr, input bit upd, input logic [7:0] wd,
                       input logic [4:0] ua, input logic [4:0] fa, input bit fw,
                       input logic [7:0] fwd);
    logic [7:0] nmem [32];
    logic [7:0] n_rdata, n_fab, n_wdata;
    logic [4:0] n_waddr;
    int         n_ptr;
    user_r_mem_8_rden      = rd;
    user_w_mem_8_wren      = wr;
    user_w_mem_8_data      = wd;
    user_mem_8_addr_update = upd;
    user_mem_8_addr        = ua;
    fab_addr               = fa;
    fab_wren               = fw;
    fab_wdata              = fwd;
    user_r_mem_8_open      = 1'($urandom);
    user_w_mem_8_open      = 1'($urandom);

    nmem    = mdl_mem;
    n_rdata = rd ? mdl_mem[mdl_ptr] : exp_rdata;
    n_fab   = mdl_mem[fa];
    n_waddr = wr ? 5'(mdl_ptr) : exp_waddr;
    n_wdata = wr ? wd : exp_wdata;
    if (fw && !(wr && (int'(fa) == mdl_ptr))) nmem[fa] = fwd;
    if (wr) nmem[mdl_ptr] = wd;
    if (upd) n_ptr = int'(ua);
    else if (rd || wr) n_ptr = (mdl_ptr + 1) % 32;
    else n_ptr = mdl_ptr;

    @(posedge bus_clk);
    #1;
    mdl_mem   = nmem;
    mdl_ptr   = n_ptr;
    exp_rdata = n_rdata;
    exp_fab   = n_fab;
    exp_stb   = wr;
    exp_waddr = n_waddr;
    exp_wdata = n_wdata;
  endtask

  task automatic seek(input logic [4:0] a);           drive(0, 0, 1, 8'h00, a, 5'd0, 0, 8'h00); endtask
  task automatic hwrite(input logic [7:0] d);         drive(0, 1, 0, d, 5'd0, 5'd0, 0, 8'h00); endtask
  task automatic hread();                              drive(1, 0, 0, 8'h00, 5'd0, 5'd0, 0, 8'h00); endtask
  task automatic fread(input logic [4:0] a);          drive(0, 0, 0, 8'h00, 5'd0, a, 0, 8'h00); endtask
  task automatic fwrite(input logic [4:0] a, input logic [7:0] d); drive(0, 0, 0, 8'h00, 5'd0, a, 1, d); endtask

  task automatic apply_reset();
    trn_reset_n            = 1'b0;
    user_r_mem_8_rden      = 1'b0;
    user_w_mem_8_wren      = 1'b0;
    user_mem_8_addr_update = 1'b0;
    fab_wren               = 1'b0;
    fab_addr               = 5'd0;
    model_reset();
    repeat (2) @(posedge bus_clk);
    #1;
    trn_reset_n = 1'b1;
  endtask

  initial begin
    bit rd, wr, upd, fw;
    logic [4:0] fa;
    model_reset();
    apply_reset();
    check("lit_reset_rdata", user_r_mem_8_data, 8'h00);
    check("lit_reset_stb", host_wr_stb, 1'b0);

    hread();
    check("lit_read_ptr0", user_r_mem_8_data, 8'h00);

    seek(5'd5);
    hwrite(8'hA1);
    check("lit_stb_addr5", {host_wr_stb, host_wr_addr, host_wr_data}, {1'b1, 5'd5, 8'hA1});
    hwrite(8'hB2);
    check("lit_stb_addr6", {host_wr_stb, host_wr_addr, host_wr_data}, {1'b1, 5'd6, 8'hB2});
    hwrite(8'hC3);
    check("lit_stb_addr7", {host_wr_stb, host_wr_addr, host_wr_data}, {1'b1, 5'd7, 8'hC3});
    hwrite(8'hD4);
    check("lit_ptr8_after_burst", host_wr_addr, 5'd8);
    fread(5'd6);
    check("lit_fab_mem6", fab_rdata, 8'hB2);

    seek(5'd30);
    hwrite(8'h11);
    hwrite(8'h22);
    hwrite(8'h33);
    check("lit_wrap_addr0", host_wr_addr, 5'd0);
    seek(5'd30);
    hread();
    check("lit_read30", user_r_mem_8_data, 8'h11);
    hread();
    check("lit_read31", user_r_mem_8_data, 8'h22);
    hread();
    check("lit_read0_wrap", user_r_mem_8_data, 8'h33);

    seek(5'd9);
    drive(0, 1, 0, 8'h55, 5'd0, 5'd9, 1, 8'h66);
    check("lit_collide_stb", host_wr_stb, 1'b1);
    fread(5'd9);
    check("lit_collide_host_wins", fab_rdata, 8'h55);

    fwrite(5'd3, 8'h7E);
    check("lit_fab_no_stb", host_wr_stb, 1'b0);
    seek(5'd3);
    hread();
    check("lit_host_sees_fab", user_r_mem_8_data, 8'h7E);

    seek(5'd4);
    hwrite(8'h44);
    fwrite(5'd12, 8'hCC);
    seek(5'd4);
    drive(1, 0, 1, 8'h00, 5'd12, 5'd0, 0, 8'h00);
    check("lit_seek_read_old_ptr", user_r_mem_8_data, 8'h44);
    hread();
    check("lit_seek_no_incr", user_r_mem_8_data, 8'hCC);

    seek(5'd20);
    hwrite(8'hE1);
    hwrite(8'hE2);
    trn_reset_n = 1'b0;
    #1;
    check("lit_midreset_outs", {user_r_mem_8_data, fab_rdata, host_wr_stb, host_wr_addr, host_wr_data}, '0);
    apply_reset();
    fread(5'd5);
    check("lit_mem_cleared", fab_rdata, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      rd  = ($urandom % 3) == 0;
      wr  = ($urandom % 3) == 0;
      upd = ($urandom % 6) == 0;
      fw  = ($urandom % 3) == 0;
      fa  = (($urandom % 3) == 0) ? 5'(mdl_ptr) : 5'($urandom);
      drive(rd, wr, upd, 8'($urandom), 5'($urandom), fa, fw, 8'($urandom));
      if (($urandom % 700) == 0) apply_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_xillybus_mem_8_regfile
`default_nettype wire
